// File: rtl/sort_pkg.sv
// Shared definitions for the insertion-sort node chain and its drain logic.
package sort_pkg;

    localparam int              WIDTH_DEF     = 8;
    localparam int              NUM_NODES_DEF = 8;
    localparam logic [7:0]      MAX_VAL_DEF   = 8'hFF;

    // Width of a node index; a one-node chain still gets a 1-bit index.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width able to hold a count of 0..n loaded entries.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        CLEAR  = 2'd2
    } rd_state_t;

endpackage

// File: rtl/sort_result_reader.sv
// Drains the sorted node chain: snapshots all nodes on start, streams the
// first count entries over valid/ready, then pulses clear_nodes and done.
module sort_result_reader
    import sort_pkg::*;
#(
    parameter int               WIDTH     = WIDTH_DEF,
    parameter int               NUM_NODES = NUM_NODES_DEF,
    parameter logic [WIDTH-1:0] MAX_VAL   = MAX_VAL_DEF,
    localparam int              IDX_W     = idx_w(NUM_NODES),
    localparam int              CNT_W     = cnt_w(NUM_NODES)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [CNT_W-1:0]           count,
    input  logic                       abort,
    input  logic [NUM_NODES*WIDTH-1:0] node_val,
    input  logic [NUM_NODES*IDX_W-1:0] node_idx,
    output logic                       load_inhibit,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_val,
    output logic [IDX_W-1:0]           out_idx,
    output logic                       out_last,
    output logic                       clear_nodes,
    output logic                       done
);

    localparam logic [CNT_W-1:0] NODES_C = CNT_W'(NUM_NODES);

    rd_state_t        state, state_nxt;
    logic [WIDTH-1:0] snap_val [NUM_NODES];
    logic [IDX_W-1:0] snap_idx [NUM_NODES];
    logic [IDX_W-1:0] rd_ptr, last_ptr;
    logic [CNT_W-1:0] eff_cnt;
    logic             at_last;
    logic             beat_ok;
    logic             take_start;

    // Counts above the chain length are clamped to the chain length.
    assign eff_cnt    = (count > NODES_C) ? NODES_C : count;
    assign at_last    = (rd_ptr == last_ptr);
    // Abort wins over a coincident handshake, so that beat is not accepted.
    assign beat_ok    = (state == STREAM) && out_ready && !abort;
    assign take_start = (state == IDLE) && start;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode and all control outputs, derived from registered state only.
    always_comb begin
        state_nxt    = state;
        out_valid    = 1'b0;
        out_last     = 1'b0;
        clear_nodes  = 1'b0;
        done         = 1'b0;
        load_inhibit = (state != IDLE);
        case (state)
            IDLE: begin
                if (start) state_nxt = (eff_cnt == '0) ? CLEAR : STREAM;
            end
            STREAM: begin
                out_valid = 1'b1;
                out_last  = at_last;
                if (abort)                      state_nxt = CLEAR;
                else if (out_ready && at_last)  state_nxt = CLEAR;
            end
            CLEAR: begin
                clear_nodes = 1'b1;
                done        = 1'b1;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Snapshot capture on accepted start and read-pointer advance per accepted beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            last_ptr <= '0;
            for (int i = 0; i < NUM_NODES; i++) begin
                snap_val[i] <= MAX_VAL;
                snap_idx[i] <= '0;
            end
        end else if (take_start && (eff_cnt != '0)) begin
            rd_ptr   <= '0;
            last_ptr <= IDX_W'(eff_cnt - CNT_W'(1));
            for (int i = 0; i < NUM_NODES; i++) begin
                snap_val[i] <= node_val[i*WIDTH +: WIDTH];
                snap_idx[i] <= node_idx[i*IDX_W +: IDX_W];
            end
        end else if (beat_ok && !at_last) begin
            rd_ptr <= rd_ptr + IDX_W'(1);
        end
    end

    // Data is a pure mux of frozen registers, so it holds steady under backpressure.
    assign out_val = snap_val[rd_ptr];
    assign out_idx = snap_idx[rd_ptr];

endmodule

// File: tb/tb_sort_result_reader.sv
// Self-checking bench for sort_result_reader: directed scenarios followed by
// randomized drains, checked against a queue-based model of the expected beats.
module tb_sort_result_reader;

    localparam int W  = 8;
    localparam int N  = 8;
    localparam int IW = 3;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] count = '0;
    logic          abort = 1'b0;
    logic [N*W-1:0]  node_val = '0;
    logic [N*IW-1:0] node_idx = '0;
    logic          load_inhibit;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_val;
    logic [IW-1:0] out_idx;
    logic          out_last;
    logic          clear_nodes;
    logic          done;

    int checks = 0;
    int errors = 0;
    int nv [N];
    int ni [N];

    sort_result_reader #(.WIDTH(W), .NUM_NODES(N), .MAX_VAL(8'hFF)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .count(count), .abort(abort),
        .node_val(node_val), .node_idx(node_idx), .load_inhibit(load_inhibit),
        .out_valid(out_valid), .out_ready(out_ready), .out_val(out_val),
        .out_idx(out_idx), .out_last(out_last), .clear_nodes(clear_nodes), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pack_nodes();
        for (int i = 0; i < N; i++) begin
            node_val[i*W +: W]   = W'(nv[i]);
            node_idx[i*IW +: IW] = IW'(ni[i]);
        end
    endtask

    // Ascending random values (node 0 smallest) with a random index permutation.
    task automatic rand_nodes();
        for (int i = 0; i < N; i++) begin
            nv[i] = $urandom_range(0, 254);
            ni[i] = i;
        end
        for (int i = 1; i < N; i++)
            for (int j = i; j > 0 && nv[j-1] > nv[j]; j--) begin
                int t = nv[j]; nv[j] = nv[j-1]; nv[j-1] = t;
            end
        for (int i = N - 1; i > 0; i--) begin
            int j = $urandom_range(0, i);
            int t = ni[i]; ni[i] = ni[j]; ni[j] = t;
        end
        pack_nodes();
    endtask

    // One drain, called at a negedge with the block idle. The model is the list
    // of the first min(cnt,N) node entries; every stream cycle must show the
    // next unaccepted entry, and done/clear must follow the final acceptance.
    task automatic drain(input int cnt, input int pct, input logic [31:0] pat,
                         input bit use_pat, input int abort_at, input bit freeze_test);
        int ev[$];
        int ei[$];
        int n, k, cyc;
        bit ab;
        for (int i = 0; i < N && i < cnt; i++) begin
            ev.push_back(nv[i]);
            ei.push_back(ni[i]);
        end
        n = ev.size();
        count = CW'(cnt);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        count = '0;
        chk("load_inhibit_rise", load_inhibit, 1);
        if (freeze_test) node_val = '0;
        k = 0; cyc = 0; ab = 0;
        while (k < n && !ab && cyc < 200) begin
            chk("valid", out_valid, 1);
            chk("val", out_val, ev[k]);
            chk("idx", out_idx, ei[k]);
            chk("last", out_last, (k == n - 1));
            chk("no_clear_in_stream", clear_nodes, 0);
            if (k == abort_at) begin
                abort = 1'b1;
                out_ready = 1'b1;
            end else if (use_pat) begin
                out_ready = (cyc < 32) ? pat[cyc] : 1'b1;
            end else begin
                out_ready = ($urandom_range(0, 99) < pct);
            end
            if (freeze_test && cyc == 1) start = 1'b1;
            @(negedge clk);
            if (abort) ab = 1;
            else if (out_ready) k++;
            abort = 1'b0;
            out_ready = 1'b0;
            start = 1'b0;
            cyc++;
        end
        if (cyc >= 200) chk("drain_timeout", 1, 0);
        chk("done", done, 1);
        chk("clear", clear_nodes, 1);
        chk("valid_in_clear", out_valid, 0);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("clear_one_cycle", clear_nodes, 0);
        chk("idle_inhibit", load_inhibit, 0);
        chk("idle_valid", out_valid, 0);
        if (freeze_test) pack_nodes();
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_val", out_val, 8'hFF);
        chk("rst_idx", out_idx, 0);
        chk("rst_last", out_last, 0);
        chk("rst_clear", clear_nodes, 0);
        chk("rst_done", done, 0);
        chk("rst_inhibit", load_inhibit, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Full drain with the reference node contents
        nv = '{3, 5, 7, 9, 10, 20, 30, 40};
        ni = '{2, 0, 5, 1, 7, 3, 6, 4};
        pack_nodes();
        drain(8, 100, 32'h0, 0, -1, 0);

        // Backpressure: ready 1,0,0,1,0,1
        drain(3, 0, 32'b101001, 1, -1, 0);

        // Saturation and zero count
        drain(12, 100, 32'h0, 0, -1, 0);
        drain(0, 100, 32'h0, 0, -1, 0);

        // Abort with ready high once two beats are accepted
        drain(8, 100, 32'h0, 0, 2, 0);

        // Snapshot freeze plus a start pulse during the stream
        drain(8, 100, 32'h0, 0, -1, 1);

        // Synchronous reset mid-stream
        count = CW'(8);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("pre_rst_valid", out_valid, 1);
        chk("pre_rst_val", out_val, nv[2]);
        rst_n = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        count = '0;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_val", out_val, 8'hFF);
        chk("midrst_idx", out_idx, 0);
        chk("midrst_inhibit", load_inhibit, 0);
        chk("midrst_clear", clear_nodes, 0);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_no_clear", clear_nodes, 0);
            chk("post_rst_no_valid", out_valid, 0);
        end
        drain(8, 100, 32'h0, 0, -1, 0);

        // Randomized drains
        repeat (25) begin
            int c, p, a;
            rand_nodes();
            c = $urandom_range(0, 12);
            p = $urandom_range(20, 100);
            a = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : -1;
            drain(c, p, 32'h0, 0, a, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sort_result_reader.md
# sort_result_reader

Drain side of the insertion-sort node chain. After the chain has been loaded, this block snapshots every node's stored minimum value and index, then streams the first `count` entries out in ascending order over a valid/ready interface. When streaming finishes, it pulses the chain-wide `clear` so the sorter is ready for the next batch. It sits between the node array and the downstream consumer, and holds off loading while it is busy.

## Interface
Parameters:
- `WIDTH`, 8: value width.
- `NUM_NODES`, 8: number of nodes in the chain.
- `MAX_VAL`, `8'hFF`: empty-slot value; used only in the reset value of `out_val`.
- `IDX_W` (localparam): `$clog2(NUM_NODES)`.
- `CNT_W` (localparam): `$clog2(NUM_NODES+1)`.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: synchronous, active-low reset.
- `start`, in, 1: begin a drain. Sampled only in IDLE.
- `count`, in, CNT_W: number of loaded entries. Sampled with `start`; saturates at NUM_NODES.
- `abort`, in, 1: drop the remaining entries and go to clear.
- `node_val`, in, NUM_NODES*WIDTH: node i's stored minimum, at bits [i*WIDTH +: WIDTH]. Node 0 holds the smallest.
- `node_idx`, in, NUM_NODES*IDX_W: node i's stored index, at bits [i*IDX_W +: IDX_W].
- `load_inhibit`, out, 1: high whenever the state is not IDLE. The controller must hold `mode_load` low while this is high.
- `out_valid`, out, 1: output beat is valid.
- `out_ready`, in, 1: consumer accepts the beat.
- `out_val`, out, WIDTH: sorted value.
- `out_idx`, out, IDX_W: original index of that value.
- `out_last`, out, 1: marks the final beat of the drain.
- `clear_nodes`, out, 1: one-cycle clear pulse to all nodes.
- `done`, out, 1: one-cycle completion pulse.

## Operation
State machine with three states: IDLE, STREAM, CLEAR.

- **IDLE**
  - `start` with an effective count n = min(count, NUM_NODES) > 0:
    - load snapshot registers from `node_val`/`node_idx`;
    - set `rd_ptr`=0 and `last_ptr`=n-1;
    - go to STREAM.
  - `start` with n = 0: go directly to CLEAR. No beats are produced.
- **STREAM**
  - `out_valid`=1. `out_val`/`out_idx` show `snap[rd_ptr]`. `out_last`=(rd_ptr==last_ptr).
  - On each handshake (`out_valid` && `out_ready`):
    - if not last, increment `rd_ptr`;
    - if last, go to CLEAR.
  - Output data must be stable while `out_valid`=1 and `out_ready`=0.
  - `abort`=1 goes to CLEAR, ignoring `out_ready` that cycle. `abort` takes priority over a simultaneous handshake, so that beat is not counted as accepted.
- **CLEAR**
  - `clear_nodes`=1 and `done`=1 for exactly one cycle.
  - Then go to IDLE.
- The snapshot is frozen for the whole drain. Changes on `node_val`/`node_idx` after `start` have no effect.
- `start` outside IDLE is ignored. `abort` outside STREAM is ignored.
- `rd_ptr` never wraps. It stops at `last_ptr`.

## Timing
- Reset (`rst_n`=0 at a rising edge) forces:
  - state=IDLE, `rd_ptr`=0;
  - `out_valid`=0, `out_last`=0, `clear_nodes`=0, `done`=0, `load_inhibit`=0;
  - `out_val`=MAX_VAL, `out_idx`=0.
- Reset mid-drain abandons the drain with no `clear_nodes` pulse.
- `start` accepted at edge E: `out_valid`=1 in the cycle after E (latency 1).
- Throughput: with `out_ready` held at 1, one beat per cycle.
- With `out_ready` held at 1, n beats occupy cycles E+1..E+n. `clear_nodes` and `done` are then high in cycle E+n+1, and the block is back in IDLE in cycle E+n+2.
- With n=0: `clear_nodes`/`done` are high in cycle E+1.
- All outputs are registered or decoded from the registered state. There is no combinational path from `out_ready` to `out_valid`.
- `load_inhibit` rises in the cycle after `start` is accepted and falls in the cycle after CLEAR.

## Structure
- Shared package `sort_pkg` holds:
  - the `WIDTH`/`NUM_NODES`/`MAX_VAL` defaults;
  - the `IDX_W`/`CNT_W` helper functions;
  - enum `rd_state_t` {IDLE, STREAM, CLEAR}.
- Single module. No sub-module is needed: the snapshot is a flat register array read through a `rd_ptr` mux.

## Test plan
- **Full drain:** nodes hold vals {3,5,7,9,10,20,30,40}, idx {2,0,5,1,7,3,6,4}; count=8, `out_ready`=1 → 8 consecutive beats in that order, `out_last` on val 40, then one `clear_nodes`+`done` cycle.
- **Backpressure:** count=3, `out_ready` toggling 1,0,0,1,0,1 → beats 3,5,7 each held stable while stalled, no duplicates or drops.
- **Saturation and zero count:**
  - count=12 → exactly 8 beats;
  - count=0 → no `out_valid`, `clear_nodes`/`done` in the cycle after `start`.
- **Abort:** count=8, `abort` together with `out_ready` after beat 2 has been accepted → 2 beats only, `clear_nodes` next cycle, then back in IDLE.
- **Snapshot freeze and ignored start:** change `node_val` to all 8'h00 and pulse `start` during STREAM → the original values still stream out and the second `start` is ignored.
- **Synchronous reset:** assert `rst_n`=0 mid-STREAM → after the edge `out_valid`=0, `out_val`=8'hFF, `clear_nodes` never pulses; then a new `start` drains normally.
